sdr_init_seq: RTL

- SDRAM power-up and initialization sequencer that drives the SDRAM command bus directly, ahead of the per-bank command traffic.
- Issues the JEDEC-style sequence: power-up wait with CKE high, PRECHARGE ALL, NUM_AREF AUTO REFRESH commands, then LOAD MODE REGISTER.
- Produces sdr_init_done, the qualifier consumed by the bus-level bank-state checker and by the main controller, which takes ownership of the bus once done is high.
- Also supports software-requested re-initialization without repeating the power-up wait.

---
 rtl/sdr_init_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdr_init_seq.sv
// sdr_init_seq - SDRAM power-up / initialization sequencer.
//
// Drives the SDRAM command bus from reset until the device is ready:
// power-up NOP wait with CKE high, PRECHARGE ALL, NUM_AREF AUTO REFRESH
// commands separated by tRFC, then LOAD MODE REGISTER followed by tMRD.
// Once finished, sdr_init_done goes high and the bus is handed to the
// main controller. A pulse on init_req while done re-runs the sequence
// from PRECHARGE ALL (the power-up wait is not repeated).
//
// Ports:
//   sdram_clk      in   SDRAM clock, rising edge
//   sdram_reset    in   asynchronous active-high reset
//   init_req       in   re-initialization request (sampled only when done)
//   sdr_cke        out  clock enable
//   sdr_cs_n       out  chip select
//   sdr_ras_n      out  RAS
//   sdr_cas_n      out  CAS
//   sdr_we_n       out  write enable
//   sdr_ba         out  bank address
//   sdr_addr       out  address / mode register value
//   sdr_dqm        out  data mask (SDR_BW bits)
//   sdr_init_done  out  initialization complete
//   init_busy      out  sequence in progress
module sdr_init_seq #(
    parameter int          SDR_BW    = 2,
    parameter int          PWRUP_CYC = 20000,
    parameter int          TRP_CYC   = 2,
    parameter int          TRFC_CYC  = 7,
    parameter int          TMRD_CYC  = 2,
    parameter int          NUM_AREF  = 8,
    parameter logic [12:0] MODE_REG  = 13'h033
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              init_req,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [12:0]       sdr_addr,
    output logic [SDR_BW-1:0] sdr_dqm,
    output logic              sdr_init_done,
    output logic              init_busy
);

    localparam int M1    = (PWRUP_CYC > TRFC_CYC) ? PWRUP_CYC : TRFC_CYC;
    localparam int M2    = (TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC;
    localparam int MAXC  = (M1 > M2) ? M1 : M2;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int REF_W = $clog2(NUM_AREF + 1);

    localparam logic [CNT_W-1:0] PWR_C   = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0] TRP_M1  = CNT_W'(TRP_CYC - 1);
    localparam logic [CNT_W-1:0] TRFC_M1 = CNT_W'(TRFC_CYC - 1);
    localparam logic [CNT_W-1:0] TMRD_M1 = CNT_W'(TMRD_CYC - 1);
    localparam logic [REF_W-1:0] NAREF_C = REF_W'(NUM_AREF);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [2:0] {
        S_PWRUP, S_PRE, S_WAIT_TRP, S_AREF,
        S_WAIT_TRFC, S_LMR, S_WAIT_TMRD, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic              enter;

    logic              cke_q, cke_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [1:0]        ba_q, ba_d;
    logic [12:0]       addr_q, addr_d;
    logic [SDR_BW-1:0] dqm_q, dqm_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // cnt_q counts the cycles already presented in the current state.
    // In PWRUP it starts at 0 out of reset, so PWRUP shows exactly
    // PWRUP_CYC cycles; every other state is entered with cnt=1.
    // ref_q is the number of AUTO REFRESH commands issued so far.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        enter   = 1'b0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_C) begin
                    state_d = S_PRE;
                    enter   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRE: begin
                state_d = (TRP_CYC == 1) ? S_AREF : S_WAIT_TRP;
                enter   = 1'b1;
            end
            S_WAIT_TRP: begin
                if (cnt_q == TRP_M1) begin
                    state_d = S_AREF;
                    enter   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_AREF: begin
                if (TRFC_CYC == 1) begin
                    state_d = (ref_q == NAREF_C) ? S_LMR : S_AREF;
                end else begin
                    state_d = S_WAIT_TRFC;
                end
                enter = 1'b1;
            end
            S_WAIT_TRFC: begin
                if (cnt_q == TRFC_M1) begin
                    state_d = (ref_q == NAREF_C) ? S_LMR : S_AREF;
                    enter   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LMR: begin
                state_d = (TMRD_CYC == 1) ? S_DONE : S_WAIT_TMRD;
                enter   = 1'b1;
            end
            S_WAIT_TMRD: begin
                if (cnt_q == TMRD_M1) begin
                    state_d = S_DONE;
                    enter   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (init_req) begin
                    state_d = S_PRE;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = S_PWRUP;
                enter   = 1'b1;
            end
        endcase

        // Counters reload on every state entry, so neither ever wraps.
        if (enter) begin
            cnt_d = CNT_W'(1);
            if (state_d == S_PRE) begin
                ref_d = '0;
            end else if (state_d == S_AREF) begin
                ref_d = ref_q + REF_W'(1);
            end
        end
    end

    // Output registers are loaded from the state being entered, so the
    // bus reflects a state in the same cycle the state register holds it.
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        ba_d   = 2'b00;
        addr_d = 13'h0000;
        dqm_d  = '1;
        done_d = 1'b0;
        busy_d = 1'b1;

        case (state_d)
            S_PRE:  begin
                cmd_d  = CMD_PRE;
                addr_d = 13'h0400;    // A10 high selects all banks
            end
            S_AREF: cmd_d = CMD_AREF;
            S_LMR:  begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            S_DONE: begin
                dqm_d  = '0;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DESEL;
            ba_q    <= 2'b00;
            addr_q  <= 13'h0000;
            dqm_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            dqm_q   <= dqm_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sdr_cke = cke_q;
    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_ba        = ba_q;
    assign sdr_addr      = addr_q;
    assign sdr_dqm       = dqm_q;
    assign sdr_init_done = done_q;
    assign init_busy     = busy_q;

endmodule
